// File: rtl/a_mat_pkg.sv
// Shared matrix-A constants and the fetch controller state encoding.
package a_mat_pkg;
   localparam int ELEM_W = 7;
   localparam int ROWS   = 8;
   localparam int COLS   = 4;
   localparam int WORD_W = 14;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/a_word_fifo.sv
// Two-entry word FIFO between the A ROM read port and the element serializer.
module a_word_fifo #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);
   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_q, wr_d, rd_q, rd_d;
   logic [1:0]        occ_q, occ_d;
   logic              do_push, do_pop;

   always_comb begin
      do_pop  = pop && (occ_q != 2'd0);
      do_push = push && ((occ_q != 2'd2) || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = ~wr_q;
      end
      if (do_pop) rd_d = ~rd_q;
      occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   assign dout = mem_q[rd_q];
   assign occ  = occ_q;
endmodule

// File: rtl/a_fetch_ctrl.sv
// Streams the 8x4 matrix-A ROM (16 words, 2 elements each) as 32 elements over valid/ready.
// Optional: define A_FETCH_STALL_CNT_EN to add the stall_cnt output.
module a_fetch_ctrl #(
   parameter int ELEM_W    = 7,
   parameter int NUM_WORDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [3:0]        rom_addr,
   input  logic [13:0]       A_input,
   output logic [ELEM_W-1:0] a_elem,
   output logic [2:0]        a_row,
   output logic [1:0]        a_col,
   output logic              a_valid,
   input  logic              a_ready,
   output logic              a_last,
   output logic              busy,
   output logic              done
`ifdef A_FETCH_STALL_CNT_EN
   ,output logic [15:0]      stall_cnt
`endif
);
   import a_mat_pkg::*;

   state_e      state_q, state_d;
   logic [3:0]  nxt_q, nxt_d;
   logic [3:0]  rom_addr_q, rom_addr_d;
   logic        infl_q, infl_d;
   logic [4:0]  idx_q, idx_d;
   logic        issue, hs, pop;
   logic [1:0]  occ;
   logic [13:0] head;

   a_word_fifo #(.W(WORD_W)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (infl_q),
      .din  (A_input),
      .pop  (pop),
      .dout (head),
      .occ  (occ)
   );

   // The address goes out in the issue cycle so a registered ROM returns the word next cycle.
   always_comb begin
      issue      = (state_q == FETCH) && ((occ == 2'd0) || (occ == 2'd1 && !infl_q));
      a_valid    = (occ != 2'd0);
      hs         = a_valid && a_ready;
      pop        = hs && idx_q[0];
      state_d    = state_q;
      nxt_d      = issue ? nxt_q + 4'd1 : nxt_q;
      idx_d      = hs ? idx_q + 5'd1 : idx_q;
      infl_d     = issue;
      rom_addr_d = issue ? nxt_q : rom_addr_q;
      case (state_q)
         IDLE:  if (start) begin
                   state_d = FETCH;
                   nxt_d   = 4'd0;
                   idx_d   = 5'd0;
                end
         FETCH: if (issue && nxt_q == 4'(NUM_WORDS - 1)) state_d = DRAIN;
         DRAIN: if (hs && idx_q == 5'(2 * NUM_WORDS - 1)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         nxt_q      <= 4'd0;
         rom_addr_q <= 4'd0;
         infl_q     <= 1'b0;
         idx_q      <= 5'd0;
      end else begin
         state_q    <= state_d;
         nxt_q      <= nxt_d;
         rom_addr_q <= rom_addr_d;
         infl_q     <= infl_d;
         idx_q      <= idx_d;
      end
   end

   // Element index maps directly: row = idx[2:0], col = idx[4:3], idx[0] selects low half.
   assign rom_addr = rom_addr_d;
   assign a_elem   = !a_valid ? '0 : (idx_q[0] ? head[ELEM_W-1:0] : head[2*ELEM_W-1:ELEM_W]);
   assign a_row    = a_valid ? idx_q[2:0] : 3'd0;
   assign a_col    = a_valid ? idx_q[4:3] : 2'd0;
   assign a_last   = a_valid && (idx_q == 5'(2 * NUM_WORDS - 1));
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

`ifdef A_FETCH_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start) stall_d = 16'd0;
      else if (a_valid && !a_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= 16'd0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_a_fetch_ctrl.sv
// Directed bench for a_fetch_ctrl with a registered ROM model driving A_input.
module tb_a_fetch_ctrl;
   logic        clk, rst, start, a_ready;
   logic [3:0]  rom_addr;
   logic [13:0] A_input;
   logic [6:0]  a_elem;
   logic [2:0]  a_row;
   logic [1:0]  a_col;
   logic        a_valid, a_last, busy, done;
`ifdef A_FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   a_fetch_ctrl #(.ELEM_W(7), .NUM_WORDS(16)) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .A_input(A_input),
      .a_elem(a_elem), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
      .a_ready(a_ready), .a_last(a_last), .busy(busy), .done(done)
`ifdef A_FETCH_STALL_CNT_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] rom [16];
   always @(posedge clk) A_input <= rom[rom_addr];

   int checks = 0, errors = 0;
   int got_elem[64], got_row[64], got_col[64], got_last[64];
   int n_got, n_valid, n_stall, hold_err, first_valid, last_cyc, done_cyc, stall_addrs;
   int st_elem, st_row, st_col;
   int addr_log[$];

   task automatic init_rom(input bit force3);
      for (int i = 0; i < 16; i++) begin
         if (i < 4) rom[i] = {7'(2 * i + 1), 7'(2 * i + 2)};
         else       rom[i] = {7'd1, 7'd1};
      end
      if (force3) rom[3] = 14'h3F80;
   endtask

   function automatic int exp_elem(input int k, input bit forced);
      if (forced && k == 6) return 127;
      if (forced && k == 7) return 0;
      return (k < 8) ? k + 1 : 1;
   endfunction

   // mode 0: ready always; 1: ready on even cycles; 2: ready low for first 5 valid cycles
   task automatic run_stream(input int mode, input int restart_at, input int rst_at, input bit start_in_done);
      bit restarted = 0, prev_hold = 0;
      int last_addr = -1, p_elem = 0, p_row = 0, p_col = 0;
      n_got = 0; n_valid = 0; n_stall = 0; hold_err = 0; first_valid = -1;
      last_cyc = -1; done_cyc = -1; stall_addrs = -1; st_elem = -1; st_row = -1; st_col = -1;
      addr_log.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == 0);
         if (restart_at >= 0 && !restarted && n_got == restart_at) begin start = 1; restarted = 1; end
         if (start_in_done && done) start = 1;
         case (mode)
            1:       a_ready = (cyc % 2 == 0);
            2:       a_ready = !(a_valid && n_valid < 5);
            default: a_ready = 1;
         endcase
         @(negedge clk);
         if (cyc >= 1 && int'(rom_addr) != last_addr) begin
            addr_log.push_back(int'(rom_addr)); last_addr = int'(rom_addr);
         end
         if (a_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            if (prev_hold && (a_elem != 7'(p_elem) || a_row != 3'(p_row) || a_col != 2'(p_col))) hold_err++;
         end
         if (a_valid && !a_ready) begin
            if (n_stall == 0) begin st_elem = a_elem; st_row = a_row; st_col = a_col; end
            n_stall++; stall_addrs = addr_log.size();
         end
         prev_hold = a_valid && !a_ready;
         p_elem = a_elem; p_row = a_row; p_col = a_col;
         if (a_valid && a_ready && n_got < 64) begin
            got_elem[n_got] = a_elem; got_row[n_got] = a_row; got_col[n_got] = a_col;
            got_last[n_got] = a_last; last_cyc = cyc; n_got++;
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (rst_at >= 0 && n_got == rst_at) begin
            #1 rst = 1; #1;
            break;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      end
      start = 0;
      if (rst_at < 0 && done_cyc < 0) begin
         errors++; $display("FAIL stream_timeout got=no_done exp=done mode=%0d", mode);
      end
   endtask

   task automatic test_reset;
      rst = 0; start = 0; a_ready = 0;
      #1 rst = 1; #2;
      checks++; if (a_valid !== 0 || busy !== 0 || done !== 0 || rom_addr !== 0) begin
         errors++; $display("FAIL reset_ctrl got=v%0d b%0d d%0d a%0d exp=0", a_valid, busy, done, rom_addr); end
      checks++; if (a_elem !== 0 || a_row !== 0 || a_col !== 0 || a_last !== 0) begin
         errors++; $display("FAIL reset_elem got=%0d/%0d/%0d/%0d exp=0", a_elem, a_row, a_col, a_last); end
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 0 || a_valid !== 0 || rom_addr !== 0) begin
         errors++; $display("FAIL reset_idle got=b%0d v%0d a%0d exp=0", busy, a_valid, rom_addr); end
   endtask

   task automatic test_full_rate;
      int nlast = 0;
      init_rom(0);
      run_stream(0, -1, -1, 0);
      checks++; if (n_got !== 32) begin errors++; $display("FAIL full_count got=%0d exp=32", n_got); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (got_elem[k] != exp_elem(k, 0) || got_row[k] != k % 8 || got_col[k] != k / 8) begin
            errors++; $display("FAIL full_elem k=%0d got=%0d r%0d c%0d exp=%0d r%0d c%0d", k,
                               got_elem[k], got_row[k], got_col[k], exp_elem(k, 0), k % 8, k / 8); end
         nlast += got_last[k];
      end
      checks++; if (got_last[31] !== 1 || nlast !== 1) begin
         errors++; $display("FAIL full_last got=%0d/%0d exp=1/1", got_last[31], nlast); end
      checks++; if (addr_log.size() !== 16) begin
         errors++; $display("FAIL full_addr_count got=%0d exp=16", addr_log.size()); end
      for (int i = 0; i < addr_log.size() && i < 16; i++) begin
         checks++; if (addr_log[i] !== i) begin
            errors++; $display("FAIL full_addr i=%0d got=%0d exp=%0d", i, addr_log[i], i); end
      end
      checks++; if (last_cyc - first_valid !== 31) begin
         errors++; $display("FAIL full_throughput got=%0d exp=31", last_cyc - first_valid); end
      checks++; if (done_cyc !== last_cyc + 1) begin
         errors++; $display("FAIL full_done got=%0d exp=%0d", done_cyc, last_cyc + 1); end
      checks++; if (busy !== 0 || done !== 0 || rom_addr !== 15) begin
         errors++; $display("FAIL full_after got=b%0d d%0d a%0d exp=0/0/15", busy, done, rom_addr); end
`ifdef A_FETCH_STALL_CNT_EN
      checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL full_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
   endtask

   task automatic test_backpressure;
      init_rom(0);
      run_stream(2, -1, -1, 0);
      checks++; if (n_stall !== 5 || hold_err !== 0) begin
         errors++; $display("FAIL bp_stall got=%0d holderr=%0d exp=5/0", n_stall, hold_err); end
      checks++; if (st_elem !== 1 || st_row !== 0 || st_col !== 0) begin
         errors++; $display("FAIL bp_held got=%0d r%0d c%0d exp=1 r0 c0", st_elem, st_row, st_col); end
      checks++; if (stall_addrs !== 2) begin
         errors++; $display("FAIL bp_issue_stop got=%0d exp=2", stall_addrs); end
      checks++; if (n_got !== 32) begin errors++; $display("FAIL bp_count got=%0d exp=32", n_got); end
      for (int k = 0; k < 32; k++) begin
         checks++; if (got_elem[k] != exp_elem(k, 0) || got_row[k] != k % 8 || got_col[k] != k / 8) begin
            errors++; $display("FAIL bp_elem k=%0d got=%0d exp=%0d", k, got_elem[k], exp_elem(k, 0)); end
      end
`ifdef A_FETCH_STALL_CNT_EN
      checks++; if (stall_cnt !== 5) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt); end
`endif
   endtask

   task automatic test_toggle_ready;
      init_rom(0);
      run_stream(1, -1, -1, 0);
      checks++; if (n_got !== 32) begin errors++; $display("FAIL tog_count got=%0d exp=32", n_got); end
      checks++; if (n_valid !== 64 || last_cyc - first_valid + 1 !== 64) begin
         errors++; $display("FAIL tog_window got=%0d/%0d exp=64", n_valid, last_cyc - first_valid + 1); end
      for (int k = 0; k < 32; k++) begin
         checks++; if (got_elem[k] != exp_elem(k, 0) || got_row[k] != k % 8 || got_col[k] != k / 8) begin
            errors++; $display("FAIL tog_elem k=%0d got=%0d r%0d c%0d exp=%0d", k, got_elem[k],
                               got_row[k], got_col[k], exp_elem(k, 0)); end
      end
   endtask

   task automatic test_restart_ignored;
      init_rom(0);
      run_stream(0, 10, -1, 1);
      checks++; if (n_got !== 32 || addr_log.size() !== 16) begin
         errors++; $display("FAIL rs_count got=%0d/%0d exp=32/16", n_got, addr_log.size()); end
      for (int k = 0; k < 32; k++) begin
         checks++; if (got_elem[k] != exp_elem(k, 0) || got_row[k] != k % 8 || got_col[k] != k / 8) begin
            errors++; $display("FAIL rs_elem k=%0d got=%0d exp=%0d", k, got_elem[k], exp_elem(k, 0)); end
      end
      checks++; if (busy !== 0) begin errors++; $display("FAIL rs_done_start got=busy%0d exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      init_rom(0);
      run_stream(0, -1, 17, 0);
      checks++; if (a_valid !== 0 || a_elem !== 0 || a_row !== 0 || a_col !== 0 || a_last !== 0) begin
         errors++; $display("FAIL mid_rst_elem got=v%0d e%0d r%0d c%0d l%0d exp=0", a_valid, a_elem, a_row, a_col, a_last); end
      checks++; if (busy !== 0 || done !== 0 || rom_addr !== 0) begin
         errors++; $display("FAIL mid_rst_ctrl got=b%0d d%0d a%0d exp=0", busy, done, rom_addr); end
      @(negedge clk) rst = 0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 0 || a_valid !== 0) begin
         errors++; $display("FAIL mid_rst_idle got=b%0d v%0d exp=0", busy, a_valid); end
      run_stream(0, -1, -1, 0);
      checks++; if (n_got !== 32 || addr_log.size() !== 16 || addr_log[0] !== 0) begin
         errors++; $display("FAIL mid_rst_rerun got=%0d/%0d exp=32/16", n_got, addr_log.size()); end
      for (int k = 0; k < 32; k++) begin
         checks++; if (got_elem[k] != exp_elem(k, 0) || got_row[k] != k % 8 || got_col[k] != k / 8) begin
            errors++; $display("FAIL mid_rst_elem k=%0d got=%0d exp=%0d", k, got_elem[k], exp_elem(k, 0)); end
      end
   endtask

   task automatic test_rom_force;
      init_rom(1);
      run_stream(0, -1, -1, 0);
      checks++; if (got_elem[6] !== 127 || got_row[6] !== 6 || got_col[6] !== 0) begin
         errors++; $display("FAIL force_e7 got=%0d r%0d c%0d exp=127 r6 c0", got_elem[6], got_row[6], got_col[6]); end
      checks++; if (got_elem[7] !== 0 || got_row[7] !== 7 || got_col[7] !== 0) begin
         errors++; $display("FAIL force_e8 got=%0d r%0d c%0d exp=0 r7 c0", got_elem[7], got_row[7], got_col[7]); end
      checks++; if (got_elem[5] !== 6 || got_elem[8] !== 1) begin
         errors++; $display("FAIL force_neighbours got=%0d/%0d exp=6/1", got_elem[5], got_elem[8]); end
      init_rom(0);
   endtask

   initial begin
      init_rom(0);
      test_reset;
      test_full_rate;
      test_backpressure;
      test_toggle_ready;
      test_restart_ignored;
      test_reset_mid;
      test_rom_force;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
